// File: rtl/phrase_match_sched.sv
// ---------------------------------------------------------------------------
// phrase_match_sched
//
// Shares a single "I Love You!" phrase matcher between up to four byte-stream
// requesters. A round-robin arbiter grants one requester for a complete
// message. The matcher compares the message bytes against the 11-byte phrase
// and reports hit / miss / timeout-abort, tagged with the requester ID.
//
// Parameters:
//   N_REQ    number of requesters (2..4); the ID is always 2 bits wide
//   TIMEOUT  consecutive stalled cycles tolerated mid-message (1..255)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester k on [8k+7:8k]
//   req_last     per-requester end-of-message flag (qualified by valid)
//   req_ready    per-requester accept, at most one bit high
//   match_valid  one-cycle result strobe
//   match_hit    message equalled the phrase (held until next result)
//   match_abort  message was ended by timeout (held until next result)
//   match_id     requester the result belongs to (held until next result)
//
// Build option:
//   PHRASE_CASE_FOLD_EN  when defined, letters compare case-insensitively;
//                        space and '!' still compare exactly.
// ---------------------------------------------------------------------------
module phrase_match_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               match_valid,
    output logic               match_hit,
    output logic               match_abort,
    output logic [1:0]         match_id
);

    localparam logic [3:0] PHRASE_LEN = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [3:0]  idx_q, idx_d;
    logic        mism_q, mism_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        abort_q, abort_d;
    logic [1:0]  id_q, id_d;

    // Phrase ROM; positions past the end are never compared (idx>=11 is a
    // mismatch on its own).
    function automatic logic [7:0] phrase_byte(input logic [3:0] i);
        case (i)
            4'd0:    phrase_byte = 8'h49;
            4'd1:    phrase_byte = 8'h20;
            4'd2:    phrase_byte = 8'h4C;
            4'd3:    phrase_byte = 8'h6F;
            4'd4:    phrase_byte = 8'h76;
            4'd5:    phrase_byte = 8'h65;
            4'd6:    phrase_byte = 8'h20;
            4'd7:    phrase_byte = 8'h59;
            4'd8:    phrase_byte = 8'h6F;
            4'd9:    phrase_byte = 8'h75;
            4'd10:   phrase_byte = 8'h21;
            default: phrase_byte = 8'h00;
        endcase
    endfunction

`ifdef PHRASE_CASE_FOLD_EN
    // Fold A-Z onto a-z; everything else passes through untouched.
    function automatic logic [7:0] fold(input logic [7:0] b);
        fold = ((b >= 8'h41) && (b <= 8'h5A)) ? (b | 8'h20) : b;
    endfunction
`else
    function automatic logic [7:0] fold(input logic [7:0] b);
        fold = b;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Ready decode: only the granted requester sees ready, and only in XFER.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == S_XFER) && (grant_q == 2'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: scan offsets from far to near so the nearest set bit
    // after last_grant is the final (winning) assignment.
    // -----------------------------------------------------------------------
    logic       pick_valid;
    logic [1:0] pick;

    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick       = last_grant_q;
        cand       = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(last_grant_q) + off) % N_REQ;
            if (req_valid[cand]) begin
                pick_valid = 1'b1;
                pick       = 2'(cand);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath for the granted requester
    // -----------------------------------------------------------------------
    logic [7:0] cur_byte;
    logic       cur_last;
    logic       accept;
    logic       byte_bad;
    logic       mism_next;
    logic [3:0] idx_next;

    assign cur_byte  = req_data[int'(grant_q)*8 +: 8];
    assign cur_last  = req_last[grant_q];
    assign accept    = req_valid[grant_q] & req_ready[grant_q];
    assign byte_bad  = (idx_q >= PHRASE_LEN) ||
                       (fold(cur_byte) != fold(phrase_byte(idx_q)));
    assign mism_next = mism_q | byte_bad;
    assign idx_next  = (idx_q == PHRASE_LEN) ? PHRASE_LEN : idx_q + 4'd1;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        mism_d       = mism_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        abort_d      = abort_q;
        id_d         = id_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    idx_d   = 4'd0;
                    mism_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                if (accept) begin
                    idx_d  = idx_next;
                    mism_d = mism_next;
                    cnt_d  = 8'd0;
                    if (cur_last) begin
                        hit_d   = !mism_next && (idx_next == PHRASE_LEN);
                        abort_d = 1'b0;
                        id_d    = grant_q;
                        state_d = S_REPORT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // This stalled cycle is the TIMEOUT-th in a row.
                    if (cnt_q == 8'(TIMEOUT - 1)) begin
                        hit_d   = 1'b0;
                        abort_d = 1'b1;
                        id_d    = grant_q;
                        state_d = S_REPORT;
                    end
                end
            end

            S_REPORT: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'(N_REQ - 1);
            idx_q        <= 4'd0;
            mism_q       <= 1'b0;
            cnt_q        <= 8'd0;
            hit_q        <= 1'b0;
            abort_q      <= 1'b0;
            id_q         <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            mism_q       <= mism_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            abort_q      <= abort_d;
            id_q         <= id_d;
        end
    end

    // Result fields are loaded on entry to REPORT, so they are already valid
    // during the strobe cycle and hold until the next result.
    assign match_valid = (state_q == S_REPORT);
    assign match_hit   = hit_q;
    assign match_abort = abort_q;
    assign match_id    = id_q;

endmodule

// File: tb/tb_phrase_match_sched.sv
// ---------------------------------------------------------------------------
// tb_phrase_match_sched
//
// Self-checking bench for phrase_match_sched. Expected results are pushed to
// a scoreboard queue as messages are launched and popped by a monitor on
// every match_valid strobe. A vector table covers single-message matching;
// hand-written sequences cover latency, round-robin order, timeout and reset.
// ---------------------------------------------------------------------------
module tb_phrase_match_sched;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 15;
`ifdef PHRASE_CASE_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               match_valid;
    logic               match_hit;
    logic               match_abort;
    logic [1:0]         match_id;

    // Per-requester drive variables, packed onto the DUT buses below.
    logic       v[N_REQ];
    logic [7:0] d[N_REQ];
    logic       l[N_REQ];

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_valid[k]       = v[k];
            req_data[8*k +: 8] = d[k];
            req_last[k]        = l[k];
        end
    end

    phrase_match_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .match_valid (match_valid),
        .match_hit   (match_hit),
        .match_abort (match_abort),
        .match_id    (match_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    typedef struct packed {
        logic       hit;
        logic       abort;
        logic [1:0] id;
    } res_t;

    res_t sb[$];

    function automatic res_t mk(input bit hit, input bit abort, input int id);
        res_t r;
        r.hit   = hit;
        r.abort = abort;
        r.id    = 2'(id);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (match_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    $display("result id=%0d hit=%0b abort=%0b (expected id=%0d hit=%0b abort=%0b)",
                             match_id, match_hit, match_abort, e.id, e.hit, e.abort);
                    check("result_id", 32'(match_id), 32'(e.id));
                    check("result_hit", 32'(match_hit), 32'(e.hit));
                    check("result_abort", 32'(match_abort), 32'(e.abort));
                end
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    // Sends msg from requester k, one byte per accepted cycle. Returns just
    // after the posedge that accepted the final byte; valid stays asserted.
    task automatic send(input int k, input string msg, input bit with_last);
        for (int i = 0; i < msg.len(); i++) begin
            int waited;
            @(negedge clk);
            v[k] = 1'b1;
            d[k] = msg.getc(i);
            l[k] = with_last && (i == msg.len() - 1);
            waited = 0;
            while (!req_ready[k]) begin
                @(negedge clk);
                waited++;
                if (waited > 300) begin
                    check("ready_wait_bound", 32'(k), 32'hFFFF);
                    return;
                end
            end
            @(posedge clk);
        end
    endtask

    task automatic release_req(input int k);
        @(negedge clk);
        v[k] = 1'b0;
        l[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        int    req;
        string msg;
        bit    hit;
    } vec_t;

    vec_t vecs[9];

    string PHRASE = "I Love You!";

    initial begin
        vecs[0] = '{0, "I Love You!",  1'b1};
        vecs[1] = '{2, "I Love Yo!",   1'b0};
        vecs[2] = '{2, "I Love You!!", 1'b0};
        vecs[3] = '{3, "I Love You!",  1'b1};
        vecs[4] = '{1, "i love you!",  FOLD};
        vecs[5] = '{0, "I Love You?",  1'b0};
        vecs[6] = '{1, "I",            1'b0};
        vecs[7] = '{3, "I LOVE YOU!",  FOLD};
        vecs[8] = '{2, "X Love You!",  1'b0};

        for (int k = 0; k < N_REQ; k++) begin
            v[k] = 1'b0;
            d[k] = 8'h00;
            l[k] = 1'b0;
        end

        // ---- reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(match_valid), 32'd0);
        check("rst_hit", 32'(match_hit), 32'd0);
        check("rst_abort", 32'(match_abort), 32'd0);
        check("rst_id", 32'(match_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- requester 0 phrase with latency checks
        sb.push_back(mk(1'b1, 1'b0, 0));
        @(negedge clk);
        v[0] = 1'b1;
        d[0] = PHRASE.getc(0);
        @(posedge clk);
        #1;
        check("grant_latency_ready", 32'(req_ready), 32'b0001);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            d[0] = PHRASE.getc(i);
            l[0] = (i == 10);
            @(posedge clk);
        end
        #1;
        check("result_latency_valid", 32'(match_valid), 32'd1);
        release_req(0);
        @(posedge clk);
        #1;
        check("strobe_one_cycle", 32'(match_valid), 32'd0);
        check("hit_held", 32'(match_hit), 32'd1);
        drain();

        // ---- table-driven single messages
        for (int t = 0; t < 9; t++) begin
            sb.push_back(mk(vecs[t].hit, 1'b0, vecs[t].req));
            send(vecs[t].req, vecs[t].msg, 1'b1);
            release_req(vecs[t].req);
            drain();
        end

        // ---- round robin: 0,1,3 all requesting -> 0,1,3,0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 0));
        sb.push_back(mk(1'b1, 1'b0, 1));
        sb.push_back(mk(1'b1, 1'b0, 3));
        sb.push_back(mk(1'b1, 1'b0, 0));
        fork
            begin send(0, PHRASE, 1'b1); send(0, PHRASE, 1'b1); release_req(0); end
            begin send(1, PHRASE, 1'b1); release_req(1); end
            begin send(3, PHRASE, 1'b1); release_req(3); end
        join
        drain();

        // ---- timeout on requester 1; requester 0 waiting gets granted next
        sb.push_back(mk(1'b0, 1'b1, 1));
        sb.push_back(mk(1'b1, 1'b0, 0));
        fork
            begin
                send(1, "I Lo", 1'b0);
                release_req(1);
                for (int i = 1; i < TIMEOUT; i++) begin
                    @(posedge clk);
                    #1;
                    check("timeout_not_early", 32'(match_valid), 32'd0);
                end
                @(posedge clk);
                #1;
                check("timeout_strobe", 32'(match_valid), 32'd1);
                check("timeout_abort", 32'(match_abort), 32'd1);
            end
            begin
                @(negedge clk);
                send(0, PHRASE, 1'b1);
                release_req(0);
            end
        join
        drain();

        // ---- reset during byte 6; afterwards requester 0 beats requester 2
        send(0, "I Lov", 1'b0);
        @(negedge clk);
        d[0] = PHRASE.getc(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_valid", 32'(match_valid), 32'd0);
        check("midrst_hit", 32'(match_hit), 32'd0);
        check("midrst_abort", 32'(match_abort), 32'd0);
        check("midrst_id", 32'(match_id), 32'd0);
        v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(1'b1, 1'b0, 0));
        sb.push_back(mk(1'b0, 1'b0, 2));
        fork
            begin send(0, PHRASE, 1'b1); release_req(0); end
            begin send(2, "I Love You", 1'b1); release_req(2); end
        join
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
